// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial add/subtract unit.
//   sa_state_t : control FSM encoding (IDLE, RUN, DONE)
//   cnt_width  : digit-counter width for an N-digit operation (at least 1 bit)
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder, purely combinational.
//   A, B, Ci : addend bits and carry-in
//   S, Co    : sum bit and carry-out
module full_adder_cell (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);

  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_adder_sub.sv
// Multi-cycle add/subtract unit. Operands are captured on start and then
// consumed DIGIT bits per clock, LSB first, through a ripple chain of
// full_adder_cell instances. The carry is held in a register between digits.
//   clk, rst        : clock, asynchronous active-high reset
//   start, sub      : request strobe and operation select (1 = subtract)
//   A, B, Ci        : operands and carry-in / borrow-in, captured at accept
//   busy, done      : busy for N cycles, then done for one cycle
//   S, Co, OV       : result, carry-out (sub: 1 = no borrow), signed overflow
module serial_adder_sub
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             OV
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);

  sa_state_t          state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, s_q;
  logic               carry_q, co_q, ov_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, last;

  // Ripple chain for one digit; c[0] is the carry carried over between clocks.
  logic [DIGIT:0]     c;
  logic [DIGIT-1:0]   dsum;
  logic [WIDTH+DIGIT-1:0] s_cat;

  assign c[0] = carry_q;

  for (genvar g = 0; g < DIGIT; g++) begin : g_cell
    full_adder_cell u_fa (
      .A  (a_sh_q[g]),
      .B  (b_sh_q[g]),
      .Ci (c[g]),
      .S  (dsum[g]),
      .Co (c[g+1])
    );
  end

  // New digit enters at the MSB end; the top WIDTH bits of the concatenation
  // are the shifted result (also valid when DIGIT == WIDTH).
  assign s_cat = {dsum, s_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: if (cnt_q == CNT_W'(N - 1)) begin
        last    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1; a borrow-in cancels the +1.
      a_sh_q  <= A;
      b_sh_q  <= sub ? ~B : B;
      carry_q <= Ci ^ sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sh_q  <= a_sh_q >> DIGIT;
      b_sh_q  <= b_sh_q >> DIGIT;
      s_q     <= s_cat[WIDTH+DIGIT-1:DIGIT];
      carry_q <= c[DIGIT];
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last) begin
        co_q <= c[DIGIT];
        ov_q <= c[DIGIT] ^ c[DIGIT-1];
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Co   = co_q;
  assign OV   = ov_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed-vector bench for serial_adder_sub: four 8-bit instances with
// DIGIT = 1, 2, 4, 8 share operand inputs, each with its own start.
module tb_serial_adder_sub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sub = 1'b0;
  logic       Ci  = 1'b0;
  logic [7:0] A   = '0;
  logic [7:0] B   = '0;
  logic [3:0] start_w = '0;
  logic [3:0] busy_w, done_w, co_w, ov_w;
  logic [7:0] s_w [4];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_adder_sub #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .start(start_w[0]), .sub(sub),
    .A(A), .B(B), .Ci(Ci), .busy(busy_w[0]), .done(done_w[0]), .S(s_w[0]), .Co(co_w[0]), .OV(ov_w[0]));
  serial_adder_sub #(.WIDTH(8), .DIGIT(2)) u1 (.clk(clk), .rst(rst), .start(start_w[1]), .sub(sub),
    .A(A), .B(B), .Ci(Ci), .busy(busy_w[1]), .done(done_w[1]), .S(s_w[1]), .Co(co_w[1]), .OV(ov_w[1]));
  serial_adder_sub #(.WIDTH(8), .DIGIT(4)) u2 (.clk(clk), .rst(rst), .start(start_w[2]), .sub(sub),
    .A(A), .B(B), .Ci(Ci), .busy(busy_w[2]), .done(done_w[2]), .S(s_w[2]), .Co(co_w[2]), .OV(ov_w[2]));
  serial_adder_sub #(.WIDTH(8), .DIGIT(8)) u3 (.clk(clk), .rst(rst), .start(start_w[3]), .sub(sub),
    .A(A), .B(B), .Ci(Ci), .busy(busy_w[3]), .done(done_w[3]), .S(s_w[3]), .Co(co_w[3]), .OV(ov_w[3]));

  typedef struct {
    int         idx;
    logic       sb;
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model built from integer arithmetic: {co, ov, s}.
  function automatic logic [9:0] model(input logic sb, input logic [7:0] a, input logic [7:0] b,
                                       input logic ci);
    int ur, sr;
    logic co, ov;
    logic [7:0] s;
    if (!sb) begin
      ur = int'(a) + int'(b) + int'(ci);
      sr = int'($signed(a)) + int'($signed(b)) + int'(ci);
      co = (ur > 255);
    end else begin
      ur = int'(a) - int'(b) - int'(ci);
      sr = int'($signed(a)) - int'($signed(b)) - int'(ci);
      co = (ur >= 0);
    end
    s  = ur[7:0];
    ov = (sr > 127) || (sr < -128);
    return {co, ov, s};
  endfunction

  // Launch one op on instance idx; lat = edges from accept to done visible,
  // bcnt = cycles busy was seen high.
  task automatic run_op(input int idx, input logic sb, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, output logic [7:0] s, output logic co, output logic ov,
                        output int lat, output int bcnt);
    @(negedge clk);
    A = a; B = b; sub = sb; Ci = ci;
    start_w[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_w[idx] = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done_w[idx] && lat < 40) begin
      if (busy_w[idx]) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    s  = s_w[idx];
    co = co_w[idx];
    ov = ov_w[idx];
  endtask

  initial begin
    logic [7:0] s;
    logic co, ov;
    logic [9:0] m;
    int lat, bcnt, pulses, dlat, k, cyc, lastc;
    logic [7:0] ea [3];
    logic [7:0] eb [3];
    logic [7:0] es [3];

    vt[0] = '{0, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[1] = '{0, 1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[2] = '{0, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vt[3] = '{2, 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vt[4] = '{1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[5] = '{3, 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[6] = '{1, 1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0};
    vt[7] = '{3, 1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[8] = '{0, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[9] = '{2, 1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_w), 32'h0);
    chk("rst_done", 32'(done_w), 32'h0);
    chk("rst_co_ov", 32'({co_w, ov_w}), 32'h0);
    chk("rst_s0", 32'(s_w[0]), 32'h0);
    chk("rst_s3", 32'(s_w[3]), 32'h0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].idx, vt[i].sb, vt[i].a, vt[i].b, vt[i].ci, s, co, ov, lat, bcnt);
      chk($sformatf("vec%0d_S", i), 32'(s), 32'(vt[i].s));
      chk($sformatf("vec%0d_Co", i), 32'(co), 32'(vt[i].co));
      chk($sformatf("vec%0d_OV", i), 32'(ov), 32'(vt[i].ov));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(8 >> vt[i].idx));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(8 >> vt[i].idx));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 32'(done_w[vt[i].idx]), 32'h0);
    end

    // start pulsed mid-RUN with new operands: ignored
    @(negedge clk);
    A = 8'h7F; B = 8'h01; sub = 1'b0; Ci = 1'b0; start_w[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (3) @(negedge clk);
    A = 8'h00; B = 8'h55; sub = 1'b1; Ci = 1'b1; start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    pulses = 0; dlat = -1; s = '0; co = 1'b0; ov = 1'b0;
    for (int i = 5; i < 25; i++) begin
      @(negedge clk);
      if (done_w[0]) begin
        pulses++;
        if (pulses == 1) begin
          dlat = i; s = s_w[0]; co = co_w[0]; ov = ov_w[0];
        end
      end
    end
    chk("midrun_pulses", 32'(pulses), 32'd1);
    chk("midrun_latency", 32'(dlat), 32'd8);
    chk("midrun_S", 32'(s), 32'h80);
    chk("midrun_Co", 32'(co), 32'h0);
    chk("midrun_OV", 32'(ov), 32'h1);

    // Asynchronous reset with cnt=3 in flight
    @(negedge clk);
    A = 8'h0F; B = 8'h01; sub = 1'b0; Ci = 1'b0; start_w[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_w[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_w[0]), 32'h0);
    chk("arst_done", 32'(done_w[0]), 32'h0);
    chk("arst_S", 32'(s_w[0]), 32'h0);
    chk("arst_Co_OV", 32'({co_w[0], ov_w[0]}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0]) pulses++;
    end
    chk("arst_no_done", 32'(pulses), 32'h0);
    run_op(0, 1'b0, 8'h0F, 8'h01, 1'b0, s, co, ov, lat, bcnt);
    chk("arst_after_S", 32'(s), 32'h10);
    chk("arst_after_lat", 32'(lat), 32'd8);

    // Back-to-back with start held high, DIGIT=2 (N=4)
    ea = '{8'h10, 8'h7F, 8'h01};
    eb = '{8'h20, 8'h7F, 8'h02};
    es = '{8'h30, 8'hFE, 8'hFF};
    @(negedge clk);
    A = ea[0]; B = eb[0]; sub = 1'b0; Ci = 1'b0; start_w[1] = 1'b1;
    cyc = 0; k = 0; lastc = -1;
    while (k < 3 && cyc < 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done_w[1]) begin
        chk($sformatf("b2b%0d_S", k), 32'(s_w[1]), 32'(es[k]));
        if (k > 0) chk($sformatf("b2b%0d_interval", k), 32'(cyc - lastc), 32'd5);
        lastc = cyc;
        k++;
        if (k < 3) begin
          A = ea[k]; B = eb[k]; sub = (k == 2);
        end
      end
    end
    start_w[1] = 1'b0;
    chk("b2b_count", 32'(k), 32'd3);
    chk("b2b_last_flags", 32'({co_w[1], ov_w[1]}), 32'b00);

    // Random ops against the integer model, 250 per DIGIT
    for (int idx = 0; idx < 4; idx++) begin
      for (int n = 0; n < 250; n++) begin
        logic sb, ci;
        logic [7:0] a, b;
        sb = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        a  = 8'($urandom_range(0, 255));
        b  = 8'($urandom_range(0, 255));
        run_op(idx, sb, a, b, ci, s, co, ov, lat, bcnt);
        m = model(sb, a, b, ci);
        chk($sformatf("rnd_d%0d_%0d sb=%0d a=%0h b=%0h ci=%0d", 1 << idx, n, sb, a, b, ci),
            32'({co, ov, s, lat[7:0]}), 32'({m, 8'(8 >> idx)}));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
